// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer.
package console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CLEAR,
    SCROLL_RD,
    SCROLL_WR,
    SCROLL_BLANK
  } state_t;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/text_console_ctrl.sv
// Writes characters into VideoRam port A, handling BS/LF/CR, scroll and clear; one char per handshake.
// All VideoRam outputs and the cursor are registered; char_ready drops while any multi-cycle phase runs.
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = ASCII_SPACE
) (
  input  logic        fpga_clk,
  input  logic        rst_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear_req,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_wren,
  input  logic [7:0]  vram_q,
  output logic [11:0] cursor_pos,
  output logic        busy
);

  localparam logic [11:0] CELLS       = 12'(COLS * ROWS);
  localparam logic [11:0] CELLS_M1    = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_ROW    = 12'(COLS * (ROWS - 1));
  localparam logic [11:0] LAST_ROW_M1 = 12'(COLS * (ROWS - 1) - 1);
  localparam logic [11:0] COLS12      = 12'(COLS);

  state_t      state, state_nxt;
  logic [11:0] cnt, cnt_nxt;
  logic [7:0]  char_q;
  logic        clr_pend, clr_pend_nxt;
  logic [11:0] addr_nxt, cursor_nxt;
  logic [7:0]  data_nxt;
  logic        wren_nxt;
  logic [11:0] row_start;
  logic        accept;

  assign row_start  = cursor_pos - (cursor_pos % COLS12);
  assign char_ready = (state == IDLE) && !clr_pend && !clear_req;
  assign busy       = (state == CLEAR) || (state == SCROLL_RD) ||
                      (state == SCROLL_WR) || (state == SCROLL_BLANK);
  assign accept     = char_valid && char_ready;

  // IDLE services both a fresh and a latched clear request, so it always drops the latch.
  assign clr_pend_nxt = (state == IDLE) ? 1'b0 : (clr_pend || clear_req);

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_pend || clear_req) state_nxt = CLEAR;
        else if (char_valid)       state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = IDLE;
        if (is_printable(char_q) && cursor_pos == CELLS_M1)     state_nxt = SCROLL_RD;
        if (char_q == ASCII_LF && row_start == LAST_ROW)          state_nxt = SCROLL_RD;
      end
      CLEAR:        if (cnt == CELLS_M1) state_nxt = IDLE;
      SCROLL_RD:    state_nxt = SCROLL_WR;
      SCROLL_WR:    state_nxt = (cnt == LAST_ROW_M1) ? SCROLL_BLANK : SCROLL_RD;
      SCROLL_BLANK: if (cnt == CELLS_M1) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // The scroll copy runs the counter up to LAST_ROW-1, so the blanking phase simply continues it.
  always_comb begin
    addr_nxt   = vram_addr;
    data_nxt   = vram_data;
    wren_nxt   = 1'b0;
    cursor_nxt = cursor_pos;
    cnt_nxt    = cnt;
    case (state)
      IDLE: cnt_nxt = 12'd0;
      WRITE: begin
        if (is_printable(char_q)) begin
          if (cursor_pos < CELLS) begin
            addr_nxt   = cursor_pos;
            data_nxt   = char_q;
            wren_nxt   = 1'b1;
            cursor_nxt = cursor_pos + 12'd1;
          end
        end else if (char_q == ASCII_BS) begin
          if (cursor_pos != 12'd0) begin
            addr_nxt   = cursor_pos - 12'd1;
            data_nxt   = BLANK;
            wren_nxt   = 1'b1;
            cursor_nxt = cursor_pos - 12'd1;
          end
        end else if (char_q == ASCII_LF) begin
          if (row_start != LAST_ROW) cursor_nxt = row_start + COLS12;
        end else if (char_q == ASCII_CR) begin
          cursor_nxt = row_start;
        end
      end
      CLEAR: begin
        addr_nxt = cnt;
        data_nxt = BLANK;
        wren_nxt = 1'b1;
        cnt_nxt  = cnt + 12'd1;
        if (cnt == CELLS_M1) cursor_nxt = 12'd0;
      end
      SCROLL_RD: addr_nxt = cnt + COLS12;
      SCROLL_WR: begin
        addr_nxt = cnt;
        data_nxt = vram_q;
        wren_nxt = 1'b1;
        cnt_nxt  = cnt + 12'd1;
      end
      SCROLL_BLANK: begin
        addr_nxt = cnt;
        data_nxt = BLANK;
        wren_nxt = 1'b1;
        cnt_nxt  = cnt + 12'd1;
        if (cnt == CELLS_M1) cursor_nxt = LAST_ROW;
      end
      default: ;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr  <= 12'd0;
      vram_data  <= 8'd0;
      vram_wren  <= 1'b0;
      cursor_pos <= 12'd0;
      cnt        <= 12'd0;
      clr_pend   <= 1'b0;
      char_q     <= 8'd0;
    end else begin
      vram_addr  <= addr_nxt;
      vram_data  <= data_nxt;
      vram_wren  <= wren_nxt;
      cursor_pos <= cursor_nxt;
      cnt        <= cnt_nxt;
      clr_pend   <= clr_pend_nxt;
      if (accept) char_q <= char_in;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomized console stimulus with a screen-array reference model and a write scoreboard.
module tb_text_console_ctrl;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic        fpga_clk;
  logic        rst_n;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        clear_req;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_wren;
  logic [7:0]  vram_q;
  logic [11:0] cursor_pos;
  logic        busy;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .fpga_clk   (fpga_clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clear_req  (clear_req),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_wren  (vram_wren),
    .vram_q     (vram_q),
    .cursor_pos (cursor_pos),
    .busy       (busy)
  );

  initial begin
    fpga_clk = 1'b0;
    forever #5 fpga_clk = ~fpga_clk;
  end

  // VideoRam port A: write on the clock, read data follows the registered address.
  logic [7:0] mem [0:4095];
  always @(posedge fpga_clk) if (vram_wren) mem[vram_addr] <= vram_data;
  assign vram_q = mem[vram_addr];

  logic [19:0] exp_q[$];
  logic [7:0]  scr [0:CELLS-1];
  int          m_cur;
  int          checks;
  int          fails;
  int          busy_cycles;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void push(input int a, input logic [7:0] d);
    exp_q.push_back({12'(a), d});
    scr[a] = d;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < CELLS; i++) push(i, BLANK);
    m_cur = 0;
  endfunction

  function automatic void model_scroll();
    for (int i = 0; i < CELLS - COLS; i++) push(i, scr[i + COLS]);
    for (int i = CELLS - COLS; i < CELLS; i++) push(i, BLANK);
    m_cur = CELLS - COLS;
  endfunction

  function automatic void model_char(input logic [7:0] ch);
    int row;
    row = m_cur / COLS;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push(m_cur, ch);
      m_cur++;
      if (m_cur == CELLS) model_scroll();
    end else if (ch == 8'h08) begin
      if (m_cur > 0) begin
        m_cur--;
        push(m_cur, BLANK);
      end
    end else if (ch == 8'h0A) begin
      if (row == ROWS - 1) model_scroll();
      else m_cur = (row + 1) * COLS;
    end else if (ch == 8'h0D) begin
      m_cur = row * COLS;
    end
  endfunction

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    busy_cycles = 0;
    do begin
      @(negedge fpga_clk);
      if (busy) busy_cycles++;
      n++;
    end while (!char_ready && n < bound);
    #1;
    if (!char_ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: char_ready still %0b after %0d cycles", char_ready, n);
    end
  endtask

  task automatic issue_char(input logic [7:0] ch);
    wait_ready(200);
    char_in    = ch;
    char_valid = 1'b1;
    model_char(ch);
    @(negedge fpga_clk);
    char_valid = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] ch);
    issue_char(ch);
    wait_ready(12000);
  endtask

  task automatic goto_last_cell();
    send_char(8'h0D);
    while (m_cur / COLS < ROWS - 1) send_char(8'h0A);
    for (int k = 0; k < COLS - 1; k++) send_char(8'(8'h61 + k % 26));
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    logic [7:0] others [6];
    others = '{8'h00, 8'h1B, 8'h7F, 8'h09, 8'h80, 8'hFF};
    r = $urandom_range(0, 99);
    if (r < 70)      return 8'($urandom_range(32, 126));
    else if (r < 78) return 8'h08;
    else if (r < 86) return 8'h0A;
    else if (r < 93) return 8'h0D;
    else             return others[$urandom_range(0, 5)];
  endfunction

  initial begin
    checks = 0;
    fails = 0;
    m_cur = 0;
    rst_n = 1'b0;
    char_in = 8'h00;
    char_valid = 1'b0;
    clear_req = 1'b0;

    fork
      forever begin
        @(negedge fpga_clk);
        if (rst_n && vram_wren) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr %0d data %h, none expected", vram_addr, vram_data);
          end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            if (e !== {vram_addr, vram_data}) begin
              fails++;
              $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                       vram_addr, vram_data, e[19:8], e[7:0]);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge fpga_clk);
    #1;
    chk("rst_wren", int'(vram_wren), 0);
    chk("rst_addr", int'(vram_addr), 0);
    chk("rst_data", int'(vram_data), 0);
    chk("rst_cursor", int'(cursor_pos), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(char_ready), 0);

    model_clear();
    @(negedge fpga_clk);
    rst_n = 1'b1;
    #1;
    chk("clear_busy", int'(busy), 1);
    wait_ready(3000);
    chk("init_cursor", int'(cursor_pos), 0);
    chk("init_queue", exp_q.size(), 0);

    send_char(8'h41);
    chk("after_A_cursor", int'(cursor_pos), m_cur);

    send_char(8'h0D);
    send_char(8'h08);
    chk("bs_at_zero_cursor", int'(cursor_pos), 0);
    for (int k = 0; k < 5; k++) send_char(8'($urandom_range(33, 126)));
    chk("five_chars_cursor", int'(cursor_pos), 5);
    send_char(8'h08);
    chk("bs_at_five_cursor", int'(cursor_pos), 4);

    for (int k = 0; k < 200; k++) begin
      send_char(rand_char());
      chk("rand_cursor", int'(cursor_pos), m_cur);
    end

    goto_last_cell();
    chk("last_cell_cursor", int'(cursor_pos), CELLS - 1);
    issue_char(8'h5A);
    wait_ready(12000);
    chk("scroll_busy_cycles", busy_cycles, 2 * (CELLS - COLS) + COLS);
    chk("scroll_cursor", int'(cursor_pos), CELLS - COLS);
    chk("scroll_queue", exp_q.size(), 0);

    wait_ready(200);
    clear_req = 1'b1;
    char_valid = 1'b1;
    char_in = 8'h58;
    #1;
    chk("clear_blocks_ready", int'(char_ready), 0);
    model_clear();
    @(negedge fpga_clk);
    clear_req = 1'b0;
    char_valid = 1'b0;
    wait_ready(3000);
    chk("clear_cursor", int'(cursor_pos), 0);

    goto_last_cell();
    issue_char(8'h51);
    repeat (100) @(negedge fpga_clk);
    #1;
    clear_req = 1'b1;
    model_clear();
    @(negedge fpga_clk);
    clear_req = 1'b0;
    wait_ready(12000);
    chk("clear_after_scroll_cursor", int'(cursor_pos), 0);
    chk("clear_after_scroll_queue", exp_q.size(), 0);

    goto_last_cell();
    issue_char(8'h52);
    repeat (1000) @(negedge fpga_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_wren", int'(vram_wren), 0);
    chk("abort_cursor", int'(cursor_pos), 0);
    exp_q.delete();
    model_clear();
    @(negedge fpga_clk);
    rst_n = 1'b1;
    wait_ready(3000);
    chk("abort_clear_cursor", int'(cursor_pos), 0);

    send_char(8'h41);
    chk("final_cursor", int'(cursor_pos), 1);
    repeat (2) @(negedge fpga_clk);
    #1;
    chk("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
